// File: rtl/uart_char_rx_if.sv
// Receive-side bundle between the UART pad logic and the character front end.
// The slave side is the receiver; the master side drives the line and baud select.
interface uart_char_rx_if;
  logic [2:0] i_baud;
  logic       i_rx;
  logic [7:0] o_char;
  logic       o_finished;
  logic       o_frame_err;

  modport master (
    output i_baud,
    output i_rx,
    input  o_char,
    input  o_finished,
    input  o_frame_err
  );

  modport slave (
    input  i_baud,
    input  i_rx,
    output o_char,
    output o_finished,
    output o_frame_err
  );
endinterface

// File: rtl/uart_char_rx.sv
// 8N1 UART receive front end: 16x oversampled start/data/stop decoding with
// majority-vote bit decisions, one-cycle character and framing-error pulses.
module uart_char_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_char_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic logic [15:0] calc_div(input int baud);
    int d;
    d = (CLK_FREQ + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    if (d < 1) d = 1;
    if (d > 65535) d = 65535;
    return d[15:0];
  endfunction

  localparam logic [15:0] DIV_0 = calc_div(2400);
  localparam logic [15:0] DIV_1 = calc_div(4800);
  localparam logic [15:0] DIV_2 = calc_div(9600);
  localparam logic [15:0] DIV_3 = calc_div(19200);
  localparam logic [15:0] DIV_4 = calc_div(38400);
  localparam logic [15:0] DIV_5 = calc_div(57600);
  localparam logic [15:0] DIV_6 = calc_div(115200);
  localparam logic [15:0] DIV_7 = calc_div(230400);

  function automatic logic [15:0] div_lookup(input logic [2:0] sel);
    logic [15:0] r;
    case (sel)
      3'd0:    r = DIV_0;
      3'd1:    r = DIV_1;
      3'd2:    r = DIV_2;
      3'd3:    r = DIV_3;
      3'd4:    r = DIV_4;
      3'd5:    r = DIV_5;
      3'd6:    r = DIV_6;
      default: r = DIV_7;
    endcase
    return r;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  state_t      state_q, state_d;
  logic [2:0]  baud_q, baud_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        s7_q, s7_d;
  logic        s8_q, s8_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_ok_q, stop_ok_d;
  logic        stop_bad_q, stop_bad_d;
  logic [7:0]  char_q, char_d;
  logic        finished_q, finished_d;
  logic        frame_err_q, frame_err_d;

  logic [15:0] div_sel;
  logic        tick;
  logic        decide;
  logic        bit_end;
  logic        maj;

  always_comb begin
    div_sel     = div_lookup(baud_q);
    tick        = (tick_cnt_q == (div_sel - 16'd1));
    decide      = tick && (samp_q == 4'd8);
    bit_end     = tick && (samp_q == 4'd15);
    maj         = majority3(s7_q, s8_q, rx_s_q);

    sync1_d     = bus.i_rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    baud_d      = baud_q;
    tick_cnt_d  = tick_cnt_q;
    samp_d      = samp_q;
    bit_idx_d   = bit_idx_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    shift_d     = shift_q;
    stop_ok_d   = 1'b0;
    stop_bad_d  = 1'b0;
    char_d      = char_q;
    finished_d  = stop_ok_q;
    frame_err_d = stop_bad_q;

    // The stop decision is registered once more so the pulse and the new
    // character appear together one cycle after the mid-stop-bit vote.
    if (stop_ok_q) char_d = shift_q;

    if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) begin
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
      if (tick) begin
        samp_d = samp_q + 4'd1;
        if (samp_q == 4'd6) s7_d = rx_s_q;
        if (samp_q == 4'd7) s8_d = rx_s_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        // IDLE is only entered with the line high, so a low level here is
        // the start-bit falling edge; counters are held clear for alignment.
        tick_cnt_d = 16'd0;
        samp_d     = 4'd0;
        if (!rx_s_q) begin
          state_d = S_START;
          baud_d  = bus.i_baud;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so a back-to-back start bit is not missed.
        if (decide) begin
          if (maj) begin
            stop_ok_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_bad_d = 1'b1;
            state_d    = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= 3'd0;
      tick_cnt_q  <= 16'd0;
      samp_q      <= 4'd0;
      bit_idx_q   <= 3'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= 8'd0;
      stop_ok_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      char_q      <= 8'd0;
      finished_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      stop_ok_q   <= stop_ok_d;
      stop_bad_q  <= stop_bad_d;
      char_q      <= char_d;
      finished_q  <= finished_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_char      = char_q;
  assign bus.o_finished  = finished_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Scoreboard bench for uart_char_rx: frames are queued as expected events when
// driven, and a monitor pops and compares on every output pulse.
module tb_uart_char_rx;

  localparam int CLK_FREQ = 3686400;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t_exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_pass;
  int   n_total;
  exp_t q[$];
  logic [7:0] last_char;
  logic prev_fin;
  logic prev_err;

  uart_char_rx_if bus ();

  uart_char_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_div(input logic [2:0] sel);
    int baud;
    int d;
    case (sel)
      3'd0:    baud = 2400;
      3'd1:    baud = 4800;
      3'd2:    baud = 9600;
      3'd3:    baud = 19200;
      3'd4:    baud = 38400;
      3'd5:    baud = 57600;
      3'd6:    baud = 115200;
      default: baud = 230400;
    endcase
    d = (CLK_FREQ + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_total = n_total + 1;
    if (ok) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    int   diff;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_char = 8'd0;
        prev_fin  = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (bus.o_finished || bus.o_frame_err) begin
          check("exclusive", !(bus.o_finished && bus.o_frame_err),
                int'(bus.o_finished) + int'(bus.o_frame_err), 1);
          check("one_cycle_pulse", !(prev_fin || prev_err),
                int'(prev_fin) + int'(prev_err), 0);
          check("pulse_expected", q.size() > 0, q.size(), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            if (e.is_err) begin
              check("frame_err_kind", bus.o_frame_err, int'(bus.o_frame_err), 1);
              check("char_held", bus.o_char == last_char, int'(bus.o_char), int'(last_char));
            end else begin
              check("finished_kind", bus.o_finished, int'(bus.o_finished), 1);
              check("char", bus.o_char == e.data, int'(bus.o_char), int'(e.data));
              diff = cyc - e.t_exp;
              check("latency", (diff >= -1) && (diff <= 1), cyc, e.t_exp);
              last_char = e.data;
            end
          end
        end
        prev_fin = bus.o_finished;
        prev_err = bus.o_frame_err;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good_stop,
                            input logic [2:0] sel, input bit scramble);
    int   d;
    exp_t e;
    d = ref_div(sel);
    bus.i_baud = sel;
    bus.i_rx   = 1'b0;
    e.is_err = !good_stop;
    e.data   = data;
    e.t_exp  = cyc + 1 + 3 + 153 * d;
    q.push_back(e);
    hold(16 * d);
    for (int b = 0; b < 8; b++) begin
      bus.i_rx = data[b];
      if (scramble && (b == 2)) begin
        hold(8 * d);
        bus.i_baud = 3'($urandom);
        hold(8 * d);
      end else begin
        hold(16 * d);
      end
    end
    bus.i_rx = good_stop;
    hold(16 * d);
    if (!good_stop) begin
      bus.i_rx = 1'b1;
      hold(32 * d);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size() == 0, q.size(), 0);
    hold(50);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    last_char  = 8'd0;
    prev_fin   = 1'b0;
    prev_err   = 1'b0;
    rst_n      = 1'b0;
    bus.i_rx   = 1'b1;
    bus.i_baud = 3'd6;
    fork
      monitor();
    join_none

    hold(5);
    check("reset_char", bus.o_char == 8'd0, int'(bus.o_char), 0);
    check("reset_finished", bus.o_finished == 1'b0, int'(bus.o_finished), 0);
    check("reset_frame_err", bus.o_frame_err == 1'b0, int'(bus.o_frame_err), 0);
    rst_n = 1'b1;
    hold(10);

    send_frame(8'hA5, 1'b1, 3'd6, 1'b0);
    hold(40);

    send_frame(8'h00, 1'b1, 3'd6, 1'b0);
    send_frame(8'hFF, 1'b1, 3'd6, 1'b0);
    send_frame(8'h55, 1'b1, 3'd6, 1'b0);
    hold(40);

    send_frame(8'h3C, 1'b0, 3'd6, 1'b0);
    send_frame(8'h81, 1'b1, 3'd6, 1'b0);
    hold(40);

    bus.i_rx = 1'b0;
    hold(6);
    bus.i_rx = 1'b1;
    hold(400);
    send_frame(8'h5A, 1'b1, 3'd6, 1'b0);
    hold(40);

    begin
      exp_t e;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      e.t_exp  = 0;
      bus.i_rx = 1'b0;
      q.push_back(e);
      hold(2000);
      bus.i_rx = 1'b1;
      hold(64);
    end
    send_frame(8'h42, 1'b1, 3'd6, 1'b0);
    drain();

    bus.i_baud = 3'd6;
    bus.i_rx   = 1'b0;
    hold(96);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_char", bus.o_char == 8'd0, int'(bus.o_char), 0);
    check("async_reset_finished", bus.o_finished == 1'b0, int'(bus.o_finished), 0);
    check("async_reset_frame_err", bus.o_frame_err == 1'b0, int'(bus.o_frame_err), 0);
    hold(3);
    bus.i_rx = 1'b1;
    rst_n    = 1'b1;
    hold(600);
    check("no_pulse_after_reset", q.size() == 0, q.size(), 0);

    send_frame(8'h7E, 1'b1, 3'd5, 1'b1);
    hold(40);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] data;
      logic [2:0] sel;
      bit         good;
      bit         scr;
      data = 8'($urandom);
      sel  = 3'(4 + $urandom_range(0, 3));
      good = ($urandom_range(0, 5) != 0);
      scr  = 1'($urandom_range(0, 1));
      send_frame(data, good, sel, scr);
      hold(7 * $urandom_range(0, 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_char_rx.md
Name: uart_char_rx

Overview:
- Serial-to-parallel front end of the UART receive path. Sits between the pad-level RX line and the receive character FIFO.
- Detects the start bit on an asynchronous 8N1 line and oversamples each bit 16x at a baud rate selected by `i_baud`.
- Assembles 8 data bits LSB-first and checks the stop bit.
- Reports each good character with a one-cycle `o_finished` pulse. Reports each bad stop bit with a one-cycle `o_frame_err` pulse.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz, used to derive the baud divisors at elaboration.
- OVERSAMPLE, 16: samples per bit period. Fixed at 16; other values are unsupported.

Ports:
- i_clk  input  1  system clock; all state on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_baud  input  3  baud select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=230400.
- i_rx  input  1  asynchronous serial line; idles high.
- o_char  output  8  last correctly received character; holds its value between frames.
- o_finished  output  1  one-cycle pulse; `o_char` is valid and new in that cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled low.

Behaviour:
- Reset (`i_rst` low, asynchronous):
  - Outputs: `o_char`=0, `o_finished`=0, `o_frame_err`=0.
  - Internal: state=IDLE, synchronizer flops=1, tick and bit counters=0.
  - Reset mid-frame discards the partial character; no pulse is emitted.
- Input synchronizer: 2-flop synchronizer on `i_rx`, both flops reset to 1. All logic uses the synchronized value `rx_s`.
- Baud divisor:
  - DIV[i] = round(CLK_FREQ / (16 * baud[i])), clamped to a minimum of 1; 16-bit constant table.
  - The tick counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - `i_baud` is latched on start detection; changes mid-frame have no effect until the next frame.
- Tick alignment: the tick counter and the 4-bit sample counter clear on entry to START, so tick phase is aligned to the detected falling edge.
- Sampling: each bit value is the majority of `rx_s` at sample counts 7, 8 and 9 of that bit. The bit decision is made at sample 9.
- State machine:
  - IDLE: wait for `rx_s` high->low, then go to START.
  - START: at the sample-9 decision, majority 1 means glitch/false start, so return to IDLE with no pulse. Majority 0 goes to DATA after sample 15, with bit index 0.
  - DATA: 8 bits LSB-first into a shift register. After the 8th bit's sample 15, go to STOP.
  - STOP: at the sample-9 decision:
    - Majority 1: load `o_char` from the shift register and pulse `o_finished` on the next cycle; go to IDLE.
    - Majority 0: pulse `o_frame_err` on the next cycle; `o_char` is unchanged; go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. A held-low line (break) yields exactly one `o_frame_err`.
- IDLE re-arm: returning to IDLE at stop-bit mid-point (not at its end) allows a back-to-back start bit to be caught.
- Exclusivity: `o_finished` and `o_frame_err` are never high in the same cycle. Each is high for exactly one clock per frame.
- Latency: `o_finished` asserts exactly 2 (sync) + 9*DIV + 9*16*DIV + 1 cycles after the first clock on which `i_rx` is sampled low. Tolerance is ±1 cycle for synchronizer metastability alignment.
- Consumer interface: there is no backpressure; the downstream stage must accept the pulse.

Test Plan:
- Bench parameters: CLK_FREQ=3686400, `i_baud`=6, so DIV=2 and the bit period is 32 clocks.
- Good frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop).
  - `o_char`=0xA5.
  - `o_finished` high for 1 cycle at 309±1 clocks after the `i_rx` fall.
  - `o_frame_err` stays 0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap. Expect 3 `o_finished` pulses 320 clocks apart carrying 0x00, 0xFF, 0x55.
- Framing error: send 0x3C with the stop bit driven low for one bit, then high.
  - One `o_frame_err` pulse; no `o_finished`.
  - `o_char` keeps its previous value.
  - The next good 0x81 is received correctly.
- False start and break:
  - A 6-clock low glitch on idle produces no pulse; state returns to IDLE.
  - Holding `i_rx` low for 2000 clocks produces exactly one `o_frame_err`.
- Reset and baud:
  - Assert `i_rst` low mid-DATA: outputs go to 0 immediately and no pulse follows.
  - After release, a frame at `i_baud`=5 (DIV=4) decodes 0x7E.
  - Toggling `i_baud` mid-frame does not corrupt that frame.
